// File: rtl/l2_bus_responder_if.sv
`default_nettype none
// ============================================================================
// Interface : l2_bus_responder_if
// Brief     : Two-port L1 miss-handler bus (port 0 = I-cache, port 1 = D-cache)
//             between the L1 requesters and the L2 responder.
// Revision  : 1.0 - initial release
// ============================================================================
interface l2_bus_responder_if;
  logic [31:0] p0_addr;
  logic        p0_rd_en;
  logic        p0_wr_en;
  logic [31:0] p0_wr_data;
  logic        p0_rd_granted;
  logic        p0_wr_granted;
  logic [31:0] p0_rd_data;

  logic [31:0] p1_addr;
  logic        p1_rd_en;
  logic        p1_wr_en;
  logic [31:0] p1_wr_data;
  logic        p1_rd_granted;
  logic        p1_wr_granted;
  logic [31:0] p1_rd_data;

  // Requester side: drives requests, receives grants and read data
  modport master (
    output p0_addr, p0_rd_en, p0_wr_en, p0_wr_data,
    input  p0_rd_granted, p0_wr_granted, p0_rd_data,
    output p1_addr, p1_rd_en, p1_wr_en, p1_wr_data,
    input  p1_rd_granted, p1_wr_granted, p1_rd_data
  );

  // Responder side
  modport slave (
    input  p0_addr, p0_rd_en, p0_wr_en, p0_wr_data,
    output p0_rd_granted, p0_wr_granted, p0_rd_data,
    input  p1_addr, p1_rd_en, p1_wr_en, p1_wr_data,
    output p1_rd_granted, p1_wr_granted, p1_rd_data
  );
endinterface
`default_nettype wire

// File: rtl/l2_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : l2_bus_responder
// Brief    : L2-side responder for the two-port L1 miss-handler bus. Round-robin
//            arbitration, programmable per-beat access delay, per-beat grant
//            pulses and a single-port word-addressed backing store.
// Revision : 1.0 - initial release
// ============================================================================
module l2_bus_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int BURST_LEN   = 4,
  parameter int MEM_AW      = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  l2_bus_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BEAT = 2'd2
  } state_t;

  // Wait counter runs 0..WAIT_CYCLES-1; beat counter runs 0..BURST_LEN
  localparam int c_WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int c_BCW = $clog2(BURST_LEN + 1);
  localparam logic [c_WCW-1:0] c_WAIT_LAST = c_WCW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [c_BCW-1:0] c_BURST     = c_BCW'(BURST_LEN);
  localparam int c_DEPTH = 1 << MEM_AW;

  state_t             r_state,    w_state_nxt;
  logic               r_owner,    w_owner_nxt;
  logic               r_is_wr,    w_is_wr_nxt;
  logic               r_rr_ptr,   w_rr_ptr_nxt;
  logic [c_BCW-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic [c_WCW-1:0]   r_wait_cnt, w_wait_cnt_nxt;
  logic [c_BCW-1:0]   w_beat_inc;
  logic [31:0]        r_p0_rd_data;
  logic [31:0]        r_p1_rd_data;
  logic [31:0]        r_mem [0:c_DEPTH-1];

  logic               w_req0, w_req1;
  logic               w_own_rd, w_own_wr, w_own_req;
  logic [MEM_AW-1:0]  w_idx;
  logic [31:0]        w_own_wdata;
  logic               w_beat;
  logic               w_unused_addr_bits;

  assign w_req0 = bus.p0_rd_en | bus.p0_wr_en;
  assign w_req1 = bus.p1_rd_en | bus.p1_wr_en;

  // Owner-side view of the bus; address is re-sampled every beat
  assign w_own_rd    = r_owner ? bus.p1_rd_en   : bus.p0_rd_en;
  assign w_own_wr    = r_owner ? bus.p1_wr_en   : bus.p0_wr_en;
  assign w_own_wdata = r_owner ? bus.p1_wr_data : bus.p0_wr_data;
  assign w_idx       = r_owner ? bus.p1_addr[MEM_AW-1:0] : bus.p0_addr[MEM_AW-1:0];
  assign w_own_req   = r_is_wr ? w_own_wr : w_own_rd;

  // Address bits above the store depth are don't-care: the index wraps
  assign w_unused_addr_bits = ^{bus.p0_addr[31:MEM_AW], bus.p1_addr[31:MEM_AW]};

  assign w_beat     = (r_state == ST_BEAT);
  assign w_beat_inc = r_beat_cnt + 1'b1;

  // Grants exist only in BEAT and only for the owner, so they are mutually exclusive
  assign bus.p0_rd_granted = w_beat & ~r_owner & ~r_is_wr;
  assign bus.p0_wr_granted = w_beat & ~r_owner &  r_is_wr;
  assign bus.p1_rd_granted = w_beat &  r_owner & ~r_is_wr;
  assign bus.p1_wr_granted = w_beat &  r_owner &  r_is_wr;
  assign bus.p0_rd_data    = r_p0_rd_data;
  assign bus.p1_rd_data    = r_p1_rd_data;

  // Control state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= 1'b0;
      r_is_wr    <= 1'b0;
      r_rr_ptr   <= 1'b0;
      r_beat_cnt <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_is_wr    <= w_is_wr_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  // Arbitration, access-delay counting and burst sequencing
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_is_wr_nxt    = r_is_wr;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 || w_req1) begin
          if (w_req0 && w_req1) begin
            w_owner_nxt  = r_rr_ptr;
            w_rr_ptr_nxt = ~r_rr_ptr;
          end else begin
            w_owner_nxt  = w_req1;
          end
          // Write wins when a port raises both enables
          w_is_wr_nxt    = w_owner_nxt ? bus.p1_wr_en : bus.p0_wr_en;
          w_beat_cnt_nxt = '0;
          w_wait_cnt_nxt = '0;
          w_state_nxt    = (WAIT_CYCLES > 0) ? ST_WAIT : ST_BEAT;
        end
      end
      ST_WAIT: begin
        if (!w_own_req) begin
          // Requester gave up before its beat: abandon without touching memory
          w_state_nxt    = ST_IDLE;
          w_beat_cnt_nxt = '0;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == c_WAIT_LAST) begin
          w_state_nxt    = ST_BEAT;
          w_wait_cnt_nxt = '0;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end
      ST_BEAT: begin
        if (!r_is_wr && (w_beat_inc < c_BURST) && w_own_rd) begin
          w_beat_cnt_nxt = w_beat_inc;
          w_state_nxt    = (WAIT_CYCLES > 0) ? ST_WAIT : ST_BEAT;
        end else begin
          // Writes are single-beat; reads stop on burst limit or dropped rd_en
          w_beat_cnt_nxt = '0;
          w_state_nxt    = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_beat_cnt_nxt = '0;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // Backing store write port; a write beat coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (rst_n && w_beat && r_is_wr) begin
      r_mem[w_idx] <= w_own_wdata;
    end
  end

  // Per-port read data, updated at the end of each read beat and held otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p0_rd_data <= '0;
      r_p1_rd_data <= '0;
    end else if (w_beat && !r_is_wr) begin
      if (r_owner) begin
        r_p1_rd_data <= r_mem[w_idx];
      end else begin
        r_p0_rd_data <= r_mem[w_idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l2_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_bus_responder
// Brief    : Self-checking bench for l2_bus_responder. Two instances are built,
//            one with a 2-cycle access delay and one with none; requester tasks
//            emulate the L1 side and compare against a word-array memory model
//            and timing derived from the bus rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_bus_responder;

  localparam int c_BURST = 4;
  localparam int c_AW    = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic [31:0] addr  [2][2];
  logic        rd_en [2][2];
  logic        wr_en [2][2];
  logic [31:0] wdata [2][2];
  logic        rdg   [2][2];
  logic        wrg   [2][2];
  logic [31:0] rdd   [2][2];

  logic [31:0] model [2][1024];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  bit          mon_en = 1'b0;

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  generate
    for (genvar d = 0; d < 2; d++) begin : g_dut
      l2_bus_responder_if u_if ();
      assign u_if.p0_addr    = addr[d][0];
      assign u_if.p0_rd_en   = rd_en[d][0];
      assign u_if.p0_wr_en   = wr_en[d][0];
      assign u_if.p0_wr_data = wdata[d][0];
      assign u_if.p1_addr    = addr[d][1];
      assign u_if.p1_rd_en   = rd_en[d][1];
      assign u_if.p1_wr_en   = wr_en[d][1];
      assign u_if.p1_wr_data = wdata[d][1];
      assign rdg[d][0] = u_if.p0_rd_granted;
      assign wrg[d][0] = u_if.p0_wr_granted;
      assign rdd[d][0] = u_if.p0_rd_data;
      assign rdg[d][1] = u_if.p1_rd_granted;
      assign wrg[d][1] = u_if.p1_wr_granted;
      assign rdd[d][1] = u_if.p1_rd_data;

      l2_bus_responder #(
        .WAIT_CYCLES ((d == 0) ? 2 : 0),
        .BURST_LEN   (c_BURST),
        .MEM_AW      (c_AW)
      ) u_dut (
        .clk   (clk),
        .rst_n (rst_n[d]),
        .bus   (u_if)
      );
    end
  endgenerate

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bus-wide invariants: never both ports granted, never rd+wr grant on one port
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        check("mutex_ports", 32'((rdg[d][0] | wrg[d][0]) & (rdg[d][1] | wrg[d][1])), 32'd0);
        check("one_grant_type", 32'((rdg[d][0] & wrg[d][0]) | (rdg[d][1] & wrg[d][1])), 32'd0);
      end
    end
  end

  task automatic check_reset_outputs(input int d);
    for (int p = 0; p < 2; p++) begin
      check("reset_rd_granted", 32'(rdg[d][p]), 32'd0);
      check("reset_wr_granted", 32'(wrg[d][p]), 32'd0);
      check("reset_rd_data", rdd[d][p], 32'd0);
    end
  endtask

  // Read requester: holds rd_en, advances address on each grant edge, drops
  // rd_en after n beats; checks beat spacing, data and absence of extra beats.
  // Entered and left #1 after a rising edge.
  task automatic do_read(input int d, input int p, input int n,
                         input logic [31:0] a0, output int first_cyc);
    int          got    = 0;
    int          budget = 0;
    int          last   = 0;
    bit          pend   = 1'b0;
    bit          g;
    logic [31:0] exp_d  = '0;
    first_cyc   = -1;
    addr[d][p]  = a0;
    rd_en[d][p] = 1'b1;
    while ((got < n || pend) && budget < 300) begin
      @(negedge clk);
      budget++;
      g = 1'b0;
      if (pend) begin
        check($sformatf("rd_data_d%0d_p%0d", d, p), rdd[d][p], exp_d);
        pend = 1'b0;
      end
      if (got >= n) begin
        check("extra_read_grant", 32'(rdg[d][p]), 32'd0);
      end else if (rdg[d][p]) begin
        if (got == 0) first_cyc = cyc;
        else check("beat_spacing", 32'(cyc - last), 32'(wait_of(d) + 1));
        last  = cyc;
        exp_d = model[d][addr[d][p][c_AW-1:0]];
        pend  = 1'b1;
        got++;
        g = 1'b1;
      end
      @(posedge clk);
      #1;
      if (g) begin
        addr[d][p] = addr[d][p] + 32'd1;
        if (got == n) rd_en[d][p] = 1'b0;
      end
    end
    rd_en[d][p] = 1'b0;
    check("read_beat_count", 32'(got), 32'(n));
  endtask

  // Write requester: one request, expects exactly one write grant and no read grant
  task automatic do_write(input int d, input int p, input logic [31:0] a,
                          input logic [31:0] data, input bit also_rd);
    int got = 0;
    bit g;
    addr[d][p]  = a;
    wdata[d][p] = data;
    wr_en[d][p] = 1'b1;
    rd_en[d][p] = also_rd;
    for (int i = 0; i < wait_of(d) + 5; i++) begin
      @(negedge clk);
      g = wrg[d][p];
      if (rdg[d][p]) check("rd_grant_during_write", 32'(rdg[d][p]), 32'd0);
      if (g) got++;
      @(posedge clk);
      #1;
      if (g) begin
        wr_en[d][p] = 1'b0;
        rd_en[d][p] = 1'b0;
      end
    end
    wr_en[d][p] = 1'b0;
    rd_en[d][p] = 1'b0;
    check("write_grant_count", 32'(got), 32'd1);
    model[d][a[c_AW-1:0]] = data;
  endtask

  initial begin
    int          c0, f0, f1, n, p, seen;
    logic [31:0] a, v;

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      for (int q = 0; q < 2; q++) begin
        addr[d][q] = '0; rd_en[d][q] = 1'b0; wr_en[d][q] = 1'b0; wdata[d][q] = '0;
      end
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    mon_en   = 1'b1;

    // Preload words 0..63 of both stores with random data through the bus
    for (int i = 0; i < 64; i++) begin
      fork
        do_write(0, i % 2, 32'(i), $urandom, 1'b0);
        do_write(1, i % 2, 32'(i), $urandom, 1'b0);
      join
    end

    // Single 4-beat burst with 2-cycle delay: first beat WAIT+1 cycles after request
    c0 = cyc;
    do_read(0, 0, 4, 32'h10, f0);
    check("first_beat_latency_w2", 32'(f0 - c0), 32'd3);

    // Simultaneous requests: p0 first from reset, then p1 first on the repeat
    c0 = cyc;
    fork
      do_read(0, 0, 4, 32'h00, f0);
      do_read(0, 1, 4, 32'h20, f1);
    join
    check("rr_round1_latency", 32'(f0 - c0), 32'd3);
    check("rr_round1_p0_first", 32'(f0 < f1), 32'd1);
    fork
      do_read(0, 0, 4, 32'h04, f0);
      do_read(0, 1, 4, 32'h28, f1);
    join
    check("rr_round2_p1_first", 32'(f1 < f0), 32'd1);

    // Address wrap: write index 0x3FF, read it back through 0x7FF
    do_write(0, 1, 32'h0000_03FF, 32'hDEAD_BEEF, 1'b0);
    do_read(0, 0, 1, 32'h0000_07FF, f0);
    check("wrap_read_data", rdd[0][0], 32'hDEAD_BEEF);

    // Both enables high: write wins, then confirm the stored word
    do_write(0, 0, 32'h20, $urandom, 1'b1);
    do_read(0, 0, 1, 32'h20, f0);

    // Random traffic, 2-cycle delay
    for (int k = 0; k < 8; k++) begin
      p = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
        do_write(0, p, 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 63)) << c_AW),
                 $urandom, 1'($urandom_range(0, 1)));
      n = int'($urandom_range(1, 4));
      a = 32'($urandom_range(0, 60)) | (32'($urandom_range(0, 63)) << c_AW);
      c0 = cyc;
      do_read(0, p, n, a, f0);
      check("rand_latency_w2", 32'(f0 - c0), 32'd3);
    end

    // Zero-delay instance: back-to-back beats following the advancing address
    for (int k = 0; k < 4; k++) begin
      p  = int'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 60)) | (32'($urandom_range(0, 63)) << c_AW);
      c0 = cyc;
      do_read(1, p, 4, a, f0);
      check("rand_latency_w0", 32'(f0 - c0), 32'd1);
    end
    fork
      do_read(1, 0, 4, 32'h08, f0);
      do_read(1, 1, 4, 32'h30, f1);
    join
    check("w0_rr_p0_first", 32'(f0 < f1), 32'd1);

    // Abort: p0 wins arbitration, drops rd_en in WAIT; p1 is then served
    c0 = cyc;
    addr[0][0]  = 32'h0;
    rd_en[0][0] = 1'b1;
    seen = 0;
    fork
      do_read(0, 1, 4, 32'h04, f1);
      begin
        @(posedge clk);
        #1;
        rd_en[0][0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
          @(negedge clk);
          if (rdg[0][0]) seen++;
        end
      end
    join
    check("abort_no_p0_grant", 32'(seen), 32'd0);
    check("abort_p1_latency", 32'(f1 - c0), 32'd5);

    // Reset during the second read beat
    addr[0][0]  = 32'h08;
    rd_en[0][0] = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && seen < 2; i++) begin
      @(negedge clk);
      if (rdg[0][0]) seen++;
    end
    check("beats_before_reset", 32'(seen), 32'd2);
    rst_n[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs(0);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    c0 = cyc;
    do_read(0, 0, 4, 32'h08, f0);
    check("restart_latency", 32'(f0 - c0), 32'd3);

    // Reset during a write beat: the write must not land
    v = model[0][10'h30];
    addr[0][0]  = 32'h30;
    wdata[0][0] = ~v;
    wr_en[0][0] = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen < 1; i++) begin
      @(negedge clk);
      if (wrg[0][0]) seen++;
    end
    check("write_beat_seen", 32'(seen), 32'd1);
    rst_n[0] = 1'b0;
    @(posedge clk);
    #1;
    wr_en[0][0] = 1'b0;
    rst_n[0]    = 1'b1;
    do_read(0, 0, 1, 32'h30, f0);
    check("write_dropped_by_reset", rdd[0][0], v);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_bus_responder.md
Name: l2_bus_responder

Overview:
- L2-side responder for the L1 miss-handler bus. It serves word reads and writes from two L1 requesters: port 0 is the I-cache and port 1 is the D-cache.
- It arbitrates round-robin between the two ports, models L2 access delay with a programmable wait count, and issues the per-beat grant pulses that drive the requesters' transfer counters.
- It holds a single-port word-addressed backing store.

Parameters:
- WAIT_CYCLES, 2, idle cycles inserted before every beat (0 allowed).
- BURST_LEN, 4, maximum read beats per ownership before re-arbitration.
- MEM_AW, 10, log2 of backing store depth in 32-bit words.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- p0_addr  in  32  port 0 word address; index = p0_addr[MEM_AW-1:0]
- p0_rd_en  in  1  port 0 read request, level, held for the whole burst
- p0_wr_en  in  1  port 0 write request, level
- p0_wr_data  in  32  port 0 write data
- p0_rd_granted  out  1  port 0 read beat pulse
- p0_wr_granted  out  1  port 0 write beat pulse
- p0_rd_data  out  32  port 0 read data, valid the cycle after p0_rd_granted
- p1_addr, p1_rd_en, p1_wr_en, p1_wr_data, p1_rd_granted, p1_wr_granted, p1_rd_data: identical for port 1

Behaviour:
- Reset: reset is rst_n, synchronous, active-low; clock is clk.
  - On reset: state=IDLE; all grant outputs 0; p0_rd_data=p1_rd_data=0; rr_ptr=0 (port 0 preferred next); beat and wait counters 0.
  - The backing store is not cleared by reset.
- Per-port request: req_n = rd_en_n | wr_en_n. If both are high, the write is served.
- Arbitration (IDLE):
  - One port requesting: that port becomes owner.
  - Both requesting: owner = rr_ptr, and rr_ptr flips to the other port.
  - The op type (write wins) is latched at arbitration.
  - Next state is WAIT if WAIT_CYCLES>0, else BEAT.
- WAIT:
  - Counts WAIT_CYCLES cycles, then goes to BEAT.
  - If the owner's latched request (rd_en or wr_en) drops: return to IDLE, no grant, no memory access, beat count cleared.
- BEAT, one cycle:
  - Exactly one of the owner's grants is high in this cycle.
  - Read: rd_data_owner <= mem[addr_owner] at the end of BEAT, so data is valid the following cycle. It holds until the next read beat to that port or reset.
  - Write: mem[addr_owner] <= wr_data_owner at the end of BEAT. A write is always a single beat, then IDLE.
  - Read, next state:
    - Beat count increments.
    - If count < BURST_LEN and the owner's rd_en is still high next cycle: WAIT, or BEAT directly if WAIT_CYCLES=0.
    - Otherwise: IDLE, count cleared.
  - Address is re-sampled at every BEAT. The requester advances its address on the grant edge, so back-to-back beats with WAIT_CYCLES=0 pick up the new address.
- Grant outputs are asserted only in BEAT. Both ports are never granted in the same cycle.
- The non-owner's request is ignored until IDLE; there is no preemption mid-burst.
- Owner's rd_en dropping in the BEAT cycle itself: the beat completes; next state is IDLE.
- After BURST_LEN beats with rd_en still high: the owner re-arbitrates from IDLE and competes normally with the other port.
- Wrap-around: address bits above MEM_AW are ignored, so the index wraps modulo 2^MEM_AW.
- Reset asserted mid-burst: immediate return to reset values; any in-flight write with reset high in BEAT is not performed.

Test Plan:
- WAIT_CYCLES=2, mem[0x10..0x13]=A0..A3; p0 rd_en held, addr 0x10 advancing on each grant -> 4 p0_rd_granted pulses spaced 3 cycles apart; p0_rd_data = A0, A1, A2, A3 one cycle after each pulse; then IDLE.
- p0 and p1 raise rd_en on the same cycle from reset -> p0 owns the full 4-beat burst first, then p1. Repeat -> p1 served first, per rr_ptr.
- p1 wr_en, addr 0x3FF, data 0xDEADBEEF -> one p1_wr_granted pulse. Then p0 read of addr 0x7FF (wraps to index 0x3FF) -> 0xDEADBEEF.
- p0 rd_en and wr_en both high, addr 0x20 -> write served, p0_wr_granted only, mem[0x20] updated, then IDLE.
- WAIT_CYCLES=0 -> 4 consecutive grant cycles; data correct per advancing address.
- Abort and reset mid-op:
  - p0 rd_en drops during WAIT -> no grant; p1 pending is served next.
  - rst_n low during beat 2 -> all outputs 0 the next cycle; a fresh burst restarts at beat 0.
